if_id_buffer: RTL and testbench
===============================

# if_id_buffer

Two-entry elastic IF/ID pipeline buffer between the fetch PC counter and the decode stage. Each cycle it captures the fetch PC, the instruction word returned for that PC, and PC+4. It presents them to decode under a valid/ready handshake. Stalls and branch/jump flushes are absorbed here, so fetch never needs a combinational path from decode.

## Interface

Parameters:
- XLEN, 32, width of PC and PC+4 fields.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
- pcf_i  input  XLEN  fetch-stage PC.
- instr_i  input  32  instruction memory read data for pcf_i.
- fetch_valid_i  input  1  pcf_i/instr_i pair is valid this cycle.
- fetch_ready_o  output  1  buffer can accept a pair this cycle.
- flush_i  input  1  redirect from EX (taken branch/jump); discard all buffered entries.
- dec_valid_o  output  1  head entry valid for decode.
- dec_ready_i  input  1  decode accepts head entry this cycle.
- instrd_o  output  32  head instruction.
- pcd_o  output  XLEN  head PC.
- pcplus4d_o  output  XLEN  head PC+4.
- occupancy_o  output  2  number of valid entries, 0..2.

## Operation

- Storage: 2 entries, each {instr, pc, pcplus4}. Implemented as a head/tail circular pair with a 2-bit count.
- Push: occurs when fetch_valid_i && fetch_ready_o && !flush_i. Writes {instr_i, pcf_i, pcf_i+4} at the tail.
- Pop: occurs when dec_valid_o && dec_ready_i && !flush_i. Advances the head.
- fetch_ready_o = (count != 2). dec_valid_o = (count != 0). Both are derived from registered count only.
- pcplus4 = pcf_i + 4, truncated to XLEN bits. 0xFFFFFFFC wraps to 0x00000000.
- Simultaneous push and pop:
  - count=1: new entry becomes head next cycle; count stays 1.
  - count=2: push is refused because fetch_ready_o=0. Pop proceeds and count becomes 1.
- Flush:
  - Takes effect on the next rising edge.
  - count←0 and head/tail pointers←0. Any push or pop in the same cycle is ignored.
  - Stored entry data is not cleared.
- Reset (low, at any time, including mid-transfer):
  - count, pointers and all entry fields go to 0 immediately, without waiting for a clock edge.
  - Output reset values: dec_valid_o=0, fetch_ready_o=1, occupancy_o=0, pcd_o=0, pcplus4d_o=0. instrd_o is 0, or 0x00000013 if NOP_ON_INVALID_EN is defined.
- Head outputs are read directly from head-entry registers. There is no combinational bypass from the inputs.

## Timing

- Push-to-visible latency: 1 cycle. A pair accepted at edge N appears on the outputs with dec_valid_o=1 after edge N.
- Full throughput, 1 entry/cycle, whenever dec_ready_i stays high.
- A decode stall of k cycles is absorbed for at most 2 fetches. fetch_ready_o drops the cycle after the second buffered entry.
- No combinational path from any input to fetch_ready_o or dec_valid_o.
- After a flush at edge N: dec_valid_o=0 and fetch_ready_o=1 from edge N onward. The first redirected fetch can be pushed in cycle N+1.

## Configuration

- Macro: IF_ID_NOP_ON_INVALID_EN.
- Defined: instrd_o is forced to 0x00000013 (addi x0,x0,0) whenever dec_valid_o=0, including during and after reset and after a flush. pcd_o and pcplus4d_o are unaffected.
- Undefined: instrd_o always shows head-entry storage, which is stale when invalid and 0 after reset. Decode must qualify it with dec_valid_o.

## Test plan

- Reset then stream:
  - Stimulus: release reset; push pc 0x0, 0x4, 0x8 with instr 0xAAAA0001, 0xAAAA0002, 0xAAAA0003; dec_ready_i=1.
  - Required response: each pair appears 1 cycle after its push; pcplus4d_o = 0x4, 0x8, 0xC; occupancy_o stays ≤1.
- Stall/backpressure:
  - Stimulus: dec_ready_i=0 while pushing pc 0x10, 0x14, 0x18.
  - Required response: after two pushes occupancy_o=2 and fetch_ready_o=0; 0x18 is not accepted; releasing dec_ready_i pops 0x10 then 0x14 in order.
- Flush while full:
  - Stimulus: occupancy_o=2; assert flush_i with fetch_valid_i=1 and pc 0x100.
  - Required response: next cycle occupancy_o=0, dec_valid_o=0, and 0x100 is not stored; a later push of 0x200 appears alone.
- Wrap-around:
  - Stimulus: push pc 0xFFFFFFFC.
  - Required response: pcplus4d_o=0x00000000.
- Asynchronous reset mid-operation:
  - Stimulus: with occupancy_o=2, drive reset low between clock edges.
  - Required response: dec_valid_o=0, occupancy_o=0, pcd_o=0 immediately, before the next edge; with IF_ID_NOP_ON_INVALID_EN defined, instrd_o=0x00000013, otherwise 0.
- Simultaneous push and pop at count=1:
  - Stimulus: push pc 0x40 while head pc 0x3C is popped.
  - Required response: next cycle pcd_o=0x40 and occupancy_o=1.

Source files
------------

// File: rtl/if_id_buffer.sv
// if_id_buffer: two-entry elastic IF/ID buffer with valid/ready handshake and flush.
// IF_ID_NOP_ON_INVALID_EN forces instrd_o to a NOP whenever no entry is valid.
module if_id_buffer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pcf_i,
    input  logic [31:0]     instr_i,
    input  logic            fetch_valid_i,
    output logic            fetch_ready_o,
    input  logic            flush_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [31:0]     instrd_o,
    output logic [XLEN-1:0] pcd_o,
    output logic [XLEN-1:0] pcplus4d_o,
    output logic [1:0]      occupancy_o
);
    logic [31:0]     instr_q [2];
    logic [XLEN-1:0] pc_q    [2];
    logic [XLEN-1:0] pc4_q   [2];
    logic [1:0]      count;
    logic            head;
    logic            tail;
    logic            push;
    logic            pop;
    always_comb begin
        fetch_ready_o = count != 2'd2;
        dec_valid_o   = count != 2'd0;
        push          = fetch_valid_i && fetch_ready_o && !flush_i;
        pop           = dec_valid_o && dec_ready_i && !flush_i;
        occupancy_o   = count;
        pcd_o         = pc_q[head];
        pcplus4d_o    = pc4_q[head];
`ifdef IF_ID_NOP_ON_INVALID_EN
        instrd_o      = dec_valid_o ? instr_q[head] : 32'h0000_0013;
`else
        instrd_o      = instr_q[head];
`endif
    end
    // Flush clears only bookkeeping; entry data stays until overwritten.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                instr_q[k] <= '0;
                pc_q[k]    <= '0;
                pc4_q[k]   <= '0;
            end
        end else if (flush_i) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (push) begin
                instr_q[tail] <= instr_i;
                pc_q[tail]    <= pcf_i;
                pc4_q[tail]   <= pcf_i + XLEN'(4);
                tail          <= ~tail;
            end
            if (pop)
                head <= ~head;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed self-checking bench for if_id_buffer.
module tb_if_id_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pcf_i = '0;
    logic [31:0] instr_i = '0;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic        flush_i = 1'b0;
    logic        dec_valid_o;
    logic        dec_ready_i = 1'b0;
    logic [31:0] instrd_o;
    logic [31:0] pcd_o;
    logic [31:0] pcplus4d_o;
    logic [1:0]  occupancy_o;
    int checks = 0;
    int errors = 0;
`ifdef IF_ID_NOP_ON_INVALID_EN
    localparam logic [31:0] INV_INSTR = 32'h0000_0013;
`else
    localparam logic [31:0] INV_INSTR = 32'h0000_0000;
`endif

    if_id_buffer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .pcf_i(pcf_i), .instr_i(instr_i),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
        .flush_i(flush_i), .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .instrd_o(instrd_o), .pcd_o(pcd_o), .pcplus4d_o(pcplus4d_o),
        .occupancy_o(occupancy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] ins, input logic dr);
        fetch_valid_i = fv;
        pcf_i = pc;
        instr_i = ins;
        dec_ready_i = dr;
        tick();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (dec_valid_o !== 1'b0 || fetch_ready_o !== 1'b1 || occupancy_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctl: valid=%b ready=%b occ=%0d, want 0 1 0", dec_valid_o, fetch_ready_o, occupancy_o);
        end
        checks++;
        if (pcd_o !== 32'h0 || pcplus4d_o !== 32'h0 || instrd_o !== INV_INSTR) begin
            errors++;
            $display("FAIL reset_data: pc=%h pc4=%h instr=%h, want 0 0 %h", pcd_o, pcplus4d_o, instrd_o, INV_INSTR);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] ins [3] = '{32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pcs[i], ins[i], 1'b1);
            checks++;
            if (dec_valid_o !== 1'b1 || pcd_o !== pcs[i] || instrd_o !== ins[i] ||
                pcplus4d_o !== pcs[i] + 32'd4 || occupancy_o !== 2'd1) begin
                errors++;
                $display("FAIL stream%0d: v=%b pc=%h ins=%h pc4=%h occ=%0d, want 1 %h %h %h 1",
                         i, dec_valid_o, pcd_o, instrd_o, pcplus4d_o, occupancy_o, pcs[i], ins[i], pcs[i] + 32'd4);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (dec_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain: v=%b occ=%0d, want 0 0", dec_valid_o, occupancy_o);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 32'h10, 32'hBBBB0010, 1'b0);
        drive(1'b1, 32'h14, 32'hBBBB0014, 1'b0);
        checks++;
        if (occupancy_o !== 2'd2 || fetch_ready_o !== 1'b0 || pcd_o !== 32'h10) begin
            errors++;
            $display("FAIL stall_full: occ=%0d ready=%b pc=%h, want 2 0 00000010", occupancy_o, fetch_ready_o, pcd_o);
        end
        drive(1'b1, 32'h18, 32'hBBBB0018, 1'b0);
        checks++;
        if (occupancy_o !== 2'd2 || pcd_o !== 32'h10 || instrd_o !== 32'hBBBB0010) begin
            errors++;
            $display("FAIL stall_hold: occ=%0d pc=%h ins=%h, want 2 00000010 bbbb0010", occupancy_o, pcd_o, instrd_o);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (occupancy_o !== 2'd1 || pcd_o !== 32'h14 || instrd_o !== 32'hBBBB0014 || fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_pop1: occ=%0d pc=%h ins=%h ready=%b, want 1 00000014 bbbb0014 1", occupancy_o, pcd_o, instrd_o, fetch_ready_o);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (occupancy_o !== 2'd0 || dec_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_pop2: occ=%0d v=%b, want 0 0 (0x18 must not be stored)", occupancy_o, dec_valid_o);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h20, 32'hCCCC0020, 1'b0);
        drive(1'b1, 32'h24, 32'hCCCC0024, 1'b0);
        flush_i = 1'b1;
        drive(1'b1, 32'h100, 32'hCCCC0100, 1'b1);
        flush_i = 1'b0;
        checks++;
        if (occupancy_o !== 2'd0 || dec_valid_o !== 1'b0 || fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: occ=%0d v=%b ready=%b, want 0 0 1", occupancy_o, dec_valid_o, fetch_ready_o);
        end
        drive(1'b1, 32'h200, 32'hCCCC0200, 1'b0);
        checks++;
        if (occupancy_o !== 2'd1 || pcd_o !== 32'h200 || instrd_o !== 32'hCCCC0200 || pcplus4d_o !== 32'h204) begin
            errors++;
            $display("FAIL flush_repush: occ=%0d pc=%h ins=%h pc4=%h, want 1 00000200 cccc0200 00000204", occupancy_o, pcd_o, instrd_o, pcplus4d_o);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (occupancy_o !== 2'd0) begin
            errors++;
            $display("FAIL flush_drain: occ=%0d, want 0", occupancy_o);
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 32'hFFFFFFFC, 32'hDDDD0001, 1'b0);
        checks++;
        if (pcd_o !== 32'hFFFFFFFC || pcplus4d_o !== 32'h0 || occupancy_o !== 2'd1) begin
            errors++;
            $display("FAIL wrap: pc=%h pc4=%h occ=%0d, want fffffffc 00000000 1", pcd_o, pcplus4d_o, occupancy_o);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_simul_push_pop();
        drive(1'b1, 32'h3C, 32'hEEEE003C, 1'b0);
        drive(1'b1, 32'h40, 32'hEEEE0040, 1'b1);
        checks++;
        if (pcd_o !== 32'h40 || occupancy_o !== 2'd1 || instrd_o !== 32'hEEEE0040 || pcplus4d_o !== 32'h44) begin
            errors++;
            $display("FAIL simul: pc=%h occ=%0d ins=%h pc4=%h, want 00000040 1 eeee0040 00000044", pcd_o, occupancy_o, instrd_o, pcplus4d_o);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (occupancy_o !== 2'd0 || dec_valid_o !== 1'b0 || instrd_o !== (INV_INSTR == 32'h0 ? 32'hEEEE003C : INV_INSTR)) begin
            errors++;
            $display("FAIL simul_drain: occ=%0d v=%b ins=%h", occupancy_o, dec_valid_o, instrd_o);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h50, 32'hFFFF0050, 1'b0);
        drive(1'b1, 32'h54, 32'hFFFF0054, 1'b0);
        fetch_valid_i = 1'b0;
        checks++;
        if (occupancy_o !== 2'd2) begin
            errors++;
            $display("FAIL areset_pre: occ=%0d, want 2", occupancy_o);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (dec_valid_o !== 1'b0 || occupancy_o !== 2'd0 || fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL areset_ctl: v=%b occ=%0d ready=%b, want 0 0 1", dec_valid_o, occupancy_o, fetch_ready_o);
        end
        checks++;
        if (pcd_o !== 32'h0 || pcplus4d_o !== 32'h0 || instrd_o !== INV_INSTR) begin
            errors++;
            $display("FAIL areset_data: pc=%h pc4=%h ins=%h, want 0 0 %h", pcd_o, pcplus4d_o, instrd_o, INV_INSTR);
        end
        #1;
        reset = 1'b1;
        tick();
        checks++;
        if (occupancy_o !== 2'd0 || dec_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL areset_post: occ=%0d v=%b, want 0 0", occupancy_o, dec_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_wrap();
        test_simul_push_pop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
